control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 164 ++++++++++++++++
 tb/tb_control_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multi-cycle processor control unit: shared three-cycle fetch followed by
// opcode-specific execute steps T3..T7, with a sticky HALT state.
module control_unit (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  output logic        PCout,
  output logic        ZLowout,
  output logic        ZHighout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        BAout,
  output logic        Cout,
  output logic        R_out,
  output logic        PC_enable,
  output logic        IR_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        Y_enable,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        HI_enable,
  output logic        LO_enable,
  output logic        R_in,
  output logic        CONin,
  output logic        OutPort_enable,
  output logic        IncPC,
  output logic        MDR_read,
  output logic        RAM_write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Run
);

  localparam logic [3:0] RST  = 4'd0;
  localparam logic [3:0] T0   = 4'd1;
  localparam logic [3:0] T1   = 4'd2;
  localparam logic [3:0] T2   = 4'd3;
  localparam logic [3:0] T3   = 4'd4;
  localparam logic [3:0] T4   = 4'd5;
  localparam logic [3:0] T5   = 4'd6;
  localparam logic [3:0] T6   = 4'd7;
  localparam logic [3:0] T7   = 4'd8;
  localparam logic [3:0] HALT = 4'd9;

  logic [3:0] state, next_state;
  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];

  logic is_ldw, is_ldwi, is_stw, is_alu, is_imm, is_muldiv, is_negnot;
  logic is_br, is_jr, is_jal, is_in, is_out, is_mfhi, is_mflo, is_halt;

  assign is_ldw    = (opcode == 5'b00000);
  assign is_ldwi   = (opcode == 5'b00001);
  assign is_stw    = (opcode == 5'b00010);
  assign is_alu    = (opcode >= 5'b00011) && (opcode <= 5'b01010);
  assign is_imm    = (opcode >= 5'b01011) && (opcode <= 5'b01101);
  assign is_muldiv = (opcode[4:1] == 4'b0111);
  assign is_negnot = (opcode[4:1] == 4'b1000);
  assign is_br     = (opcode == 5'b10010);
  assign is_jr     = (opcode == 5'b10011);
  assign is_jal    = (opcode == 5'b10100);
  assign is_in     = (opcode == 5'b10101);
  assign is_out    = (opcode == 5'b10110);
  assign is_mfhi   = (opcode == 5'b10111);
  assign is_mflo   = (opcode == 5'b11000);
  assign is_halt   = (opcode == 5'b11010);

  // Each T-state exits to T0 unless the opcode needs a further step; nop,
  // undefined opcodes and all single-cycle ops fall out of T3.
  always_comb begin
    next_state = RST;
    case (state)
      RST:  next_state = T0;
      T0:   next_state = T1;
      T1:   next_state = T2;
      T2:   next_state = T3;
      T3: begin
        if (is_halt)
          next_state = HALT;
        else if (is_ldw | is_ldwi | is_stw | is_alu | is_imm | is_muldiv |
                 is_negnot | is_br | is_jal)
          next_state = T4;
        else
          next_state = T0;
      end
      T4:   next_state = (is_ldw | is_ldwi | is_stw | is_alu | is_imm |
                          is_muldiv | is_br) ? T5 : T0;
      T5:   next_state = (is_ldw | is_stw | is_muldiv | is_br) ? T6 : T0;
      T6:   next_state = (is_ldw | is_stw) ? T7 : T0;
      T7:   next_state = T0;
      HALT: next_state = HALT;
      default: next_state = RST;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Clear) state <= RST;
    else       state <= next_state;
  end

  always_comb begin
    PCout = 1'b0; ZLowout = 1'b0; ZHighout = 1'b0; MDRout = 1'b0;
    HIout = 1'b0; LOout = 1'b0; InPortout = 1'b0; BAout = 1'b0;
    Cout = 1'b0; R_out = 1'b0;
    PC_enable = 1'b0; IR_enable = 1'b0; MAR_enable = 1'b0; MDR_enable = 1'b0;
    Y_enable = 1'b0; ZLowIn = 1'b0; ZHighIn = 1'b0; HI_enable = 1'b0;
    LO_enable = 1'b0; R_in = 1'b0; CONin = 1'b0; OutPort_enable = 1'b0;
    IncPC = 1'b0; MDR_read = 1'b0; RAM_write = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    Run = (state >= T0) && (state <= T7);
    case (state)
      T0: begin PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; end
      T1: begin ZLowout = 1'b1; PC_enable = 1'b1; MDR_read = 1'b1; MDR_enable = 1'b1; end
      T2: begin MDRout = 1'b1; IR_enable = 1'b1; end
      T3: begin
        if (is_ldw | is_ldwi | is_stw) begin Grb = 1'b1; BAout = 1'b1; Y_enable = 1'b1; end
        if (is_alu | is_imm)           begin Grb = 1'b1; R_out = 1'b1; Y_enable = 1'b1; end
        if (is_muldiv)                 begin Gra = 1'b1; R_out = 1'b1; Y_enable = 1'b1; end
        if (is_negnot)                 begin Grb = 1'b1; R_out = 1'b1; ZLowIn = 1'b1; end
        if (is_br)                     begin Gra = 1'b1; R_out = 1'b1; CONin = 1'b1; end
        if (is_jr)                     begin Gra = 1'b1; R_out = 1'b1; PC_enable = 1'b1; end
        if (is_jal)                    begin PCout = 1'b1; Grb = 1'b1; R_in = 1'b1; end
        if (is_in)                     begin InPortout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
        if (is_out)                    begin Gra = 1'b1; R_out = 1'b1; OutPort_enable = 1'b1; end
        if (is_mfhi)                   begin HIout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
        if (is_mflo)                   begin LOout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
      end
      T4: begin
        if (is_alu)                            begin Grc = 1'b1; R_out = 1'b1; ZLowIn = 1'b1; end
        if (is_imm | is_ldw | is_ldwi | is_stw) begin Cout = 1'b1; ZLowIn = 1'b1; end
        if (is_muldiv) begin Grb = 1'b1; R_out = 1'b1; ZLowIn = 1'b1; ZHighIn = 1'b1; end
        if (is_negnot)                         begin ZLowout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
        if (is_br)                             begin PCout = 1'b1; Y_enable = 1'b1; end
        if (is_jal)                            begin Gra = 1'b1; R_out = 1'b1; PC_enable = 1'b1; end
      end
      T5: begin
        if (is_alu | is_imm | is_ldwi) begin ZLowout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
        if (is_ldw | is_stw)           begin ZLowout = 1'b1; MAR_enable = 1'b1; end
        if (is_muldiv)                 begin ZLowout = 1'b1; LO_enable = 1'b1; end
        if (is_br)                     begin Cout = 1'b1; ZLowIn = 1'b1; end
      end
      T6: begin
        if (is_ldw)    begin MDR_read = 1'b1; MDR_enable = 1'b1; end
        if (is_stw)    begin Gra = 1'b1; R_out = 1'b1; MDR_enable = 1'b1; end
        if (is_muldiv) begin ZHighout = 1'b1; HI_enable = 1'b1; end
        if (is_br)     begin ZLowout = 1'b1; PC_enable = CON_FF; end
      end
      T7: begin
        if (is_ldw) begin MDRout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
        if (is_stw) RAM_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed table-driven bench for control_unit: per-opcode T3..T7 output
// vectors plus hand-written reset, halt and mid-instruction clear sequences.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        Clear = 1'b1;
  logic [31:0] IR = '0;
  logic        CON_FF = 1'b0;
  logic PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, BAout, Cout, R_out;
  logic PC_enable, IR_enable, MAR_enable, MDR_enable, Y_enable, ZLowIn, ZHighIn;
  logic HI_enable, LO_enable, R_in, CONin, OutPort_enable;
  logic IncPC, MDR_read, RAM_write, Gra, Grb, Grc, Run;

  control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF),
    .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .BAout(BAout),
    .Cout(Cout), .R_out(R_out),
    .PC_enable(PC_enable), .IR_enable(IR_enable), .MAR_enable(MAR_enable),
    .MDR_enable(MDR_enable), .Y_enable(Y_enable), .ZLowIn(ZLowIn),
    .ZHighIn(ZHighIn), .HI_enable(HI_enable), .LO_enable(LO_enable),
    .R_in(R_in), .CONin(CONin), .OutPort_enable(OutPort_enable),
    .IncPC(IncPC), .MDR_read(MDR_read), .RAM_write(RAM_write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Run(Run)
  );

  always #5 Clock = ~Clock;

  localparam logic [28:0] B_PCOUT    = 29'd1 << 0;
  localparam logic [28:0] B_ZLOWOUT  = 29'd1 << 1;
  localparam logic [28:0] B_ZHIGHOUT = 29'd1 << 2;
  localparam logic [28:0] B_MDROUT   = 29'd1 << 3;
  localparam logic [28:0] B_HIOUT    = 29'd1 << 4;
  localparam logic [28:0] B_LOOUT    = 29'd1 << 5;
  localparam logic [28:0] B_INPOUT   = 29'd1 << 6;
  localparam logic [28:0] B_BAOUT    = 29'd1 << 7;
  localparam logic [28:0] B_COUT     = 29'd1 << 8;
  localparam logic [28:0] B_ROUT     = 29'd1 << 9;
  localparam logic [28:0] B_PCEN     = 29'd1 << 10;
  localparam logic [28:0] B_IREN     = 29'd1 << 11;
  localparam logic [28:0] B_MAREN    = 29'd1 << 12;
  localparam logic [28:0] B_MDREN    = 29'd1 << 13;
  localparam logic [28:0] B_YEN      = 29'd1 << 14;
  localparam logic [28:0] B_ZLOWIN   = 29'd1 << 15;
  localparam logic [28:0] B_ZHIGHIN  = 29'd1 << 16;
  localparam logic [28:0] B_HIEN     = 29'd1 << 17;
  localparam logic [28:0] B_LOEN     = 29'd1 << 18;
  localparam logic [28:0] B_RIN      = 29'd1 << 19;
  localparam logic [28:0] B_CONIN    = 29'd1 << 20;
  localparam logic [28:0] B_OUTEN    = 29'd1 << 21;
  localparam logic [28:0] B_INCPC    = 29'd1 << 22;
  localparam logic [28:0] B_MDRREAD  = 29'd1 << 23;
  localparam logic [28:0] B_RAMWR    = 29'd1 << 24;
  localparam logic [28:0] B_GRA      = 29'd1 << 25;
  localparam logic [28:0] B_GRB      = 29'd1 << 26;
  localparam logic [28:0] B_GRC      = 29'd1 << 27;
  localparam logic [28:0] B_RUN      = 29'd1 << 28;

  localparam logic [28:0] E_T0 = B_PCOUT | B_MAREN | B_INCPC | B_ZLOWIN | B_RUN;
  localparam logic [28:0] E_T1 = B_ZLOWOUT | B_PCEN | B_MDRREAD | B_MDREN | B_RUN;
  localparam logic [28:0] E_T2 = B_MDROUT | B_IREN | B_RUN;

  logic [28:0] obs;
  assign obs = {Run, Grc, Grb, Gra, RAM_write, MDR_read, IncPC,
                OutPort_enable, CONin, R_in, LO_enable, HI_enable, ZHighIn,
                ZLowIn, Y_enable, MDR_enable, MAR_enable, IR_enable, PC_enable,
                R_out, Cout, BAout, InPortout, LOout, HIout, MDRout, ZHighout,
                ZLowout, PCout};

  typedef struct {
    string           name;
    logic [31:0]     ir;
    logic            con;
    int unsigned     n;
    logic [4:0][28:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   failed = 0;

  function automatic vec_t mk(string name, logic [31:0] ir, logic con, int unsigned n,
                              logic [28:0] e3, logic [28:0] e4, logic [28:0] e5,
                              logic [28:0] e6, logic [28:0] e7);
    vec_t v;
    v.name = name; v.ir = ir; v.con = con; v.n = n;
    v.exp[0] = e3 | B_RUN; v.exp[1] = e4 | B_RUN; v.exp[2] = e5 | B_RUN;
    v.exp[3] = e6 | B_RUN; v.exp[4] = e7 | B_RUN;
    return v;
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [28:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: outputs got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic fetch(input string name);
    chk({name, " T0"}, E_T0); step();
    chk({name, " T1"}, E_T1); step();
    chk({name, " T2"}, E_T2);
  endtask

  initial begin
    logic [28:0] ldw3, ldw4, ldw5, alu3, z_gra_rin;
    ldw3 = B_GRB | B_BAOUT | B_YEN;
    ldw4 = B_COUT | B_ZLOWIN;
    ldw5 = B_ZLOWOUT | B_MAREN;
    alu3 = B_GRB | B_ROUT | B_YEN;
    z_gra_rin = B_ZLOWOUT | B_GRA | B_RIN;

    vecs.push_back(mk("ldw", 32'h0090_0002, 1'b0, 5, ldw3, ldw4, ldw5,
                      B_MDRREAD | B_MDREN, B_MDROUT | B_GRA | B_RIN));
    vecs.push_back(mk("add", 32'h1800_0000, 1'b0, 3, alu3, B_GRC | B_ROUT | B_ZLOWIN, z_gra_rin, '0, '0));
    vecs.push_back(mk("rol", 32'h5000_0000, 1'b0, 3, alu3, B_GRC | B_ROUT | B_ZLOWIN, z_gra_rin, '0, '0));
    vecs.push_back(mk("addi", 32'h5800_0000, 1'b0, 3, alu3, ldw4, z_gra_rin, '0, '0));
    vecs.push_back(mk("ori", 32'h6800_0000, 1'b0, 3, alu3, ldw4, z_gra_rin, '0, '0));
    vecs.push_back(mk("ldwi", 32'h0800_0000, 1'b0, 3, ldw3, ldw4, z_gra_rin, '0, '0));
    vecs.push_back(mk("stw", 32'h1000_0000, 1'b0, 5, ldw3, ldw4, ldw5,
                      B_GRA | B_ROUT | B_MDREN, B_RAMWR));
    vecs.push_back(mk("mul", 32'h7000_0000, 1'b0, 4, B_GRA | B_ROUT | B_YEN,
                      B_GRB | B_ROUT | B_ZLOWIN | B_ZHIGHIN, B_ZLOWOUT | B_LOEN,
                      B_ZHIGHOUT | B_HIEN, '0));
    vecs.push_back(mk("div", 32'h7800_0000, 1'b0, 4, B_GRA | B_ROUT | B_YEN,
                      B_GRB | B_ROUT | B_ZLOWIN | B_ZHIGHIN, B_ZLOWOUT | B_LOEN,
                      B_ZHIGHOUT | B_HIEN, '0));
    vecs.push_back(mk("neg", 32'h8000_0000, 1'b0, 2, B_GRB | B_ROUT | B_ZLOWIN, z_gra_rin, '0, '0, '0));
    vecs.push_back(mk("not", 32'h8800_0000, 1'b0, 2, B_GRB | B_ROUT | B_ZLOWIN, z_gra_rin, '0, '0, '0));
    vecs.push_back(mk("br_c0", 32'h9000_0000, 1'b0, 4, B_GRA | B_ROUT | B_CONIN,
                      B_PCOUT | B_YEN, ldw4, B_ZLOWOUT, '0));
    vecs.push_back(mk("br_c1", 32'h9000_0000, 1'b1, 4, B_GRA | B_ROUT | B_CONIN,
                      B_PCOUT | B_YEN, ldw4, B_ZLOWOUT | B_PCEN, '0));
    vecs.push_back(mk("jr", 32'h9800_0000, 1'b0, 1, B_GRA | B_ROUT | B_PCEN, '0, '0, '0, '0));
    vecs.push_back(mk("jal", 32'hA000_0000, 1'b0, 2, B_PCOUT | B_GRB | B_RIN,
                      B_GRA | B_ROUT | B_PCEN, '0, '0, '0));
    vecs.push_back(mk("in", 32'hA800_0000, 1'b0, 1, B_INPOUT | B_GRA | B_RIN, '0, '0, '0, '0));
    vecs.push_back(mk("out", 32'hB000_0000, 1'b0, 1, B_GRA | B_ROUT | B_OUTEN, '0, '0, '0, '0));
    vecs.push_back(mk("mfhi", 32'hB800_0000, 1'b0, 1, B_HIOUT | B_GRA | B_RIN, '0, '0, '0, '0));
    vecs.push_back(mk("mflo", 32'hC000_0000, 1'b0, 1, B_LOOUT | B_GRA | B_RIN, '0, '0, '0, '0));
    vecs.push_back(mk("nop", 32'hC800_0000, 1'b0, 1, '0, '0, '0, '0, '0));
    vecs.push_back(mk("undef1b", 32'hD800_0000, 1'b0, 1, '0, '0, '0, '0, '0));
    vecs.push_back(mk("undef1f", 32'hFFFF_FFFF, 1'b0, 1, '0, '0, '0, '0, '0));

    // Reset held two cycles, then released into T0.
    Clear = 1'b1;
    step(); step();
    chk("reset", '0);
    Clear = 1'b0;
    step();

    foreach (vecs[i]) begin
      IR = vecs[i].ir;
      CON_FF = vecs[i].con;
      fetch(vecs[i].name);
      for (int unsigned k = 0; k < vecs[i].n; k++) begin
        step();
        chk($sformatf("%s T%0d", vecs[i].name, k + 3), vecs[i].exp[k]);
      end
      step();
    end
    chk("final T0", E_T0);

    // Halt: sticky with Run=0 until Clear.
    IR = 32'hD000_0000;
    CON_FF = 1'b0;
    fetch("halt");
    step();
    chk("halt T3", B_RUN);
    for (int h = 0; h < 10; h++) begin
      step();
      chk($sformatf("halt hold %0d", h), '0);
    end
    Clear = 1'b1;
    step();
    chk("halt clear RST", '0);
    Clear = 1'b0;
    step();
    chk("halt exit T0", E_T0);

    // Clear during ldw T5 aborts the instruction.
    IR = 32'h0090_0002;
    fetch("ldw_abort");
    step(); chk("ldw_abort T3", ldw3 | B_RUN);
    step(); chk("ldw_abort T4", ldw4 | B_RUN);
    step(); chk("ldw_abort T5", ldw5 | B_RUN);
    Clear = 1'b1;
    step();
    chk("ldw_abort RST", '0);
    Clear = 1'b0;
    step();
    chk("ldw_abort T0", E_T0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
